// File: rtl/echo_pkg.sv
// echo_pkg: shared types, pipeline constants and the saturating adder for the
// echo mixer. The optional recirculating-echo feature is ECHO_FEEDBACK_EN
// (used in echo_mixer.sv).
package echo_pkg;

    // Mixer control states. IDLE is bypass, FILL primes the delay line,
    // RUN reads one delayed sample per input sample.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } echo_state_e;

    // Cycles from rd_en to valid read data on the FIFO output.
    localparam int FIFO_RD_LAT = 2;
    // Cycles from accept to po_sample_valid.
    localparam int PIPE_LAT    = 4;

    // Working width of the saturating adder; wide enough that the sum of two
    // in-range operands of any supported sample width can never wrap.
    localparam int SAT_MAX_W = 64;
    localparam logic signed [SAT_MAX_W-1:0] SAT_ONE = 1;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of a 'width'-bit value.
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 width
    );
        logic signed [SAT_MAX_W-1:0] sum;
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        sum   = a + b;
        max_v = (SAT_ONE <<< (width - 1)) - SAT_ONE;
        min_v = -(SAT_ONE <<< (width - 1));
        if (sum > max_v) begin
            sat_add = max_v;
        end else if (sum < min_v) begin
            sat_add = min_v;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/echo_sat_mac.sv
// echo_sat_mac: scales the delayed sample by an unsigned Q0.GAIN_WIDTH gain,
// registers the product, then floors it back to sample scale and adds the
// dry sample with saturation (combinational from the product register).
module echo_sat_mac
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         sreset_i,
    input  logic                         load_i,
    input  logic signed [DATA_WIDTH-1:0] delayed_i,
    input  logic        [GAIN_WIDTH-1:0] gain_i,
    input  logic signed [DATA_WIDTH-1:0] dry_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH;

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] scaled;

    // Signed sample times zero-extended gain; the full product fits in PW bits.
    always_comb begin
        prod_d = PW'(delayed_i) * $signed(PW'(gain_i));
    end

    // Product register, loaded in the cycle the FIFO read data is valid.
    always_ff @(posedge clk_i) begin
        if (sreset_i) begin
            prod_q <= '0;
        end else if (load_i) begin
            prod_q <= prod_d;
        end
    end

    // Arithmetic shift floors toward minus infinity, then saturating add.
    always_comb begin
        scaled = prod_q >>> GAIN_WIDTH;
        sum_o  = DATA_WIDTH'(sat_add(SAT_MAX_W'(scaled), SAT_MAX_W'(dry_i), DATA_WIDTH));
    end

endmodule

// File: rtl/echo_mixer.sv
// echo_mixer: control and mix stage around the echo delay FIFO. Accepts dry
// samples, primes the FIFO to DELAY_SAMPLES, then mixes the delayed sample
// scaled by pi_gain into each output with a fixed 4-cycle latency.
// Optional: define ECHO_FEEDBACK_EN to write the mixed output (instead of the
// dry sample) back into the FIFO, giving a decaying recirculating echo.
module echo_mixer
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int MEM_DEPTH     = 4,
    parameter int DELAY_SAMPLES = 4,
    parameter int GAIN_WIDTH    = 8
) (
    input  logic                         pi_clk,
    input  logic                         pi_sreset,
    input  logic                         pi_enable,
    input  logic        [GAIN_WIDTH-1:0] pi_gain,
    input  logic                         pi_sample_valid,
    input  logic signed [DATA_WIDTH-1:0] pi_sample,
    output logic                         po_sample_valid,
    output logic signed [DATA_WIDTH-1:0] po_sample,
    output logic                         po_drop,
    output logic                         po_err,
    output logic                         po_fifo_wr_en,
    output logic                         po_fifo_rd_en,
    output logic                         po_fifo_sreset_fsm,
    output logic        [DATA_WIDTH-1:0] po_fifo_data,
    input  logic        [DATA_WIDTH-1:0] pi_fifo_data,
    input  logic                         pi_fifo_full,
    input  logic                         pi_fifo_empty
);

    // Fill counter only needs to reach DELAY_SAMPLES (<= MEM_DEPTH).
    localparam int CNT_W = $clog2(DELAY_SAMPLES + 1);

    echo_state_e state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;

    // vld_q[k] marks the in-flight sample in cycle k+1 after its accept.
    logic [PIPE_LAT-1:0]          vld_q;
    echo_state_e                  mode_q;
    logic                         rd_q;
    logic signed [DATA_WIDTH-1:0] dry_q;
    logic [GAIN_WIDTH-1:0]        gain_q;
    logic signed [DATA_WIDTH-1:0] out_q;
    logic signed [DATA_WIDTH-1:0] wdata_q;
    logic                         wr_q;
    logic                         err_q;

    logic                         busy;
    logic                         accept;
    logic                         drop;
    logic                         rd_try;
    logic                         rd_issue;
    logic                         err_set;
    logic                         flush;
    echo_state_e                  acc_mode;
    logic signed [DATA_WIDTH-1:0] delayed;
    logic signed [DATA_WIDTH-1:0] mac_sum;
    logic signed [DATA_WIDTH-1:0] wdata_src;

    // Accept/drop decision and FIFO read request in the accept cycle.
    // A sample taken while pi_enable is low always runs as bypass, so the
    // mode it carries down the pipe never depends on a later state change.
    always_comb begin
        busy     = |vld_q;
        accept   = pi_sample_valid && !busy && !pi_sreset;
        drop     = pi_sample_valid && busy && !pi_sreset;
        acc_mode = pi_enable ? state_q : ST_IDLE;
        rd_try   = accept && (acc_mode == ST_RUN);
        rd_issue = rd_try && !pi_fifo_empty;
        err_set  = rd_try && pi_fifo_empty;
        // Leaving FILL/RUN waits until the in-flight sample has produced its
        // output, so the flush never cuts a read or write in half.
        flush    = !pi_sreset && (state_q != ST_IDLE) && !pi_enable && !busy;
        delayed  = rd_q ? $signed(pi_fifo_data) : '0;
    end

`ifdef ECHO_FEEDBACK_EN
    assign wdata_src = mac_sum;
`else
    assign wdata_src = dry_q;
`endif

    // Next-state and fill-counter logic.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            ST_IDLE: begin
                fill_cnt_d = '0;
                if (pi_enable) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (wr_q) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if ((fill_cnt_d == CNT_W'(DELAY_SAMPLES)) || pi_fifo_full) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and sticky error flag.
    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Sample pipeline: latch at accept, register output and FIFO write in cycle 4.
    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            vld_q   <= '0;
            mode_q  <= ST_IDLE;
            rd_q    <= 1'b0;
            dry_q   <= '0;
            gain_q  <= '0;
            out_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            vld_q <= {vld_q[PIPE_LAT-2:0], accept};
            if (accept) begin
                dry_q  <= pi_sample;
                gain_q <= pi_gain;
                mode_q <= acc_mode;
                rd_q   <= rd_issue;
            end
            wr_q <= vld_q[PIPE_LAT-2] && (mode_q != ST_IDLE);
            if (vld_q[PIPE_LAT-2]) begin
                out_q   <= mac_sum;
                wdata_q <= wdata_src;
            end
        end
    end

    echo_sat_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_mac (
        .clk_i     (pi_clk),
        .sreset_i  (pi_sreset),
        .load_i    (vld_q[FIFO_RD_LAT-1]),
        .delayed_i (delayed),
        .gain_i    (gain_q),
        .dry_i     (dry_q),
        .sum_o     (mac_sum)
    );

    assign po_sample_valid    = vld_q[PIPE_LAT-1];
    assign po_sample          = out_q;
    assign po_drop            = drop;
    assign po_err             = err_q;
    assign po_fifo_wr_en      = wr_q;
    assign po_fifo_rd_en      = rd_issue;
    assign po_fifo_sreset_fsm = flush;
    assign po_fifo_data       = wdata_q;

endmodule

// File: tb/tb_echo_mixer.sv
// tb_echo_mixer: directed bench for echo_mixer with a behavioural echo FIFO
// (2-cycle read latency). Expected values are hand-computed for gain Q0.8.
module tb_echo_mixer;
    import echo_pkg::*;

    localparam int DW    = 16;
    localparam int GW    = 8;
    localparam int DEPTH = 4;
    localparam int DELAY = 4;
`ifdef ECHO_FEEDBACK_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    // ---------------- clock / reset / stimulus signals ----------------
    logic                 clk     = 1'b0;
    logic                 sreset  = 1'b1;
    logic                 enable  = 1'b0;
    logic [GW-1:0]        gain    = '0;
    logic                 s_valid = 1'b0;
    logic signed [DW-1:0] sample  = '0;

    logic                 out_valid;
    logic signed [DW-1:0] out_sample;
    logic                 drop;
    logic                 err;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic                 fifo_flush;
    logic [DW-1:0]        fifo_wdata;
    logic [DW-1:0]        fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;

    always #5 clk = ~clk;

    echo_mixer #(
        .DATA_WIDTH    (DW),
        .MEM_DEPTH     (DEPTH),
        .DELAY_SAMPLES (DELAY),
        .GAIN_WIDTH    (GW)
    ) dut (
        .pi_clk             (clk),
        .pi_sreset          (sreset),
        .pi_enable          (enable),
        .pi_gain            (gain),
        .pi_sample_valid    (s_valid),
        .pi_sample          (sample),
        .po_sample_valid    (out_valid),
        .po_sample          (out_sample),
        .po_drop            (drop),
        .po_err             (err),
        .po_fifo_wr_en      (fifo_wr),
        .po_fifo_rd_en      (fifo_rd),
        .po_fifo_sreset_fsm (fifo_flush),
        .po_fifo_data       (fifo_wdata),
        .pi_fifo_data       (fifo_rdata),
        .pi_fifo_full       (fifo_full),
        .pi_fifo_empty      (fifo_empty)
    );

    // ---------------- behavioural echo FIFO ----------------
    logic [DW-1:0] fq[$];
    logic [DW-1:0] rd_d1 = '0;
    logic [DW-1:0] rd_d2 = '0;
    int            fifo_cnt = 0;
    logic          force_empty = 1'b0;

    assign fifo_empty = (fifo_cnt == 0) || force_empty;
    assign fifo_full  = (fifo_cnt >= DEPTH);
    assign fifo_rdata = rd_d2;

    always @(posedge clk) begin
        logic [DW-1:0] popped;
        popped = '0;
        if (sreset || fifo_flush) begin
            fq.delete();
        end else begin
            if (fifo_rd && fq.size() > 0) popped = fq.pop_front();
            if (fifo_wr && fq.size() < DEPTH) fq.push_back(fifo_wdata);
        end
        rd_d1    <= popped;
        rd_d2    <= rd_d1;
        fifo_cnt <= fq.size();
    end

    // ---------------- checking ----------------
    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;

    always @(negedge clk) if (out_valid === 1'b1) valid_cnt++;

    task automatic check_eq(input string tag, input logic signed [31:0] act,
                            input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One sample: accept next negedge, wait (bounded) for the output strobe,
    // check latency, mixed value and FIFO write.
    task automatic send_chk(input string tag, input int s, input int g, input int exp_out,
                            input bit exp_rd, input bit exp_wr, input int exp_wdata);
        int lat;
        bit seen;
        @(negedge clk);
        s_valid = 1'b1;
        sample  = DW'(s);
        gain    = GW'(g);
        #1;
        check_eq({tag, ".rd_en"}, fifo_rd, exp_rd);
        check_eq({tag, ".drop"}, drop, 0);
        @(negedge clk);
        s_valid = 1'b0;
        sample  = '0;
        gain    = '0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 8) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check_eq({tag, ".latency"}, seen ? lat : -1, 4);
        if (seen) begin
            check_eq({tag, ".out"}, $signed(out_sample), exp_out);
            check_eq({tag, ".wr_en"}, fifo_wr, exp_wr);
            check_eq({tag, ".wdata"}, $signed(fifo_wdata), exp_wdata);
        end
    endtask

    // Drop enable with an idle pipeline (flush expected), optionally re-enable.
    task automatic restart(input string tag, input bit reenable);
        @(negedge clk);
        enable = 1'b0;
        #1;
        check_eq({tag, ".flush"}, fifo_flush, 1);
        if (reenable) begin
            @(negedge clk);
            enable = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int vc0;
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_eq("rst.valid", out_valid, 0);
        check_eq("rst.out", $signed(out_sample), 0);
        check_eq("rst.drop", drop, 0);
        check_eq("rst.err", err, 0);
        check_eq("rst.wr", fifo_wr, 0);
        check_eq("rst.rd", fifo_rd, 0);
        check_eq("rst.flush", fifo_flush, 0);
        check_eq("rst.wdata", $signed(fifo_wdata), 0);
        check_eq("rst.state", dut.state_q, ST_IDLE);
        sreset = 1'b0;

        // bypass while disabled
        send_chk("byp", 1234, 128, 1234, 0, 0, 1234);

        // ---------------- basic echo, gain 0.5 ----------------
        @(negedge clk);
        enable = 1'b1;
        send_chk("t1.s0", 1000, 128, 1000, 0, 1, 1000);
        send_chk("t1.s1", 0, 128, 0, 0, 1, 0);
        send_chk("t1.s2", 0, 128, 0, 0, 1, 0);
        send_chk("t1.s3", 0, 128, 0, 0, 1, 0);
        send_chk("t1.s4", 0, 128, 500, 1, 1, FB ? 500 : 0);
        send_chk("t1.s5", 0, 128, 0, 1, 1, 0);
        check_eq("t1.state", dut.state_q, ST_RUN);

        // ---------------- enable dropped mid-sample ----------------
        @(negedge clk);
        s_valid = 1'b1; sample = 200; gain = 128;
        #1 check_eq("t4.rd", fifo_rd, 1);
        @(negedge clk);
        s_valid = 1'b0; sample = '0; gain = '0;
        @(negedge clk);
        enable = 1'b0;
        #1 check_eq("t4.flush_c2", fifo_flush, 0);
        @(negedge clk);
        check_eq("t4.flush_c3", fifo_flush, 0);
        @(negedge clk);
        check_eq("t4.valid_c4", out_valid, 1);
        check_eq("t4.out", $signed(out_sample), 200);
        check_eq("t4.wr", fifo_wr, 1);
        check_eq("t4.flush_c4", fifo_flush, 0);
        @(negedge clk);
        check_eq("t4.flush_c5", fifo_flush, 1);
        @(negedge clk);
        check_eq("t4.flush_c6", fifo_flush, 0);
        check_eq("t4.state", dut.state_q, ST_IDLE);
        send_chk("t4.dry", 300, 128, 300, 0, 0, 300);
        @(negedge clk);
        enable = 1'b1;
        send_chk("t4.f0", 400, 128, 400, 0, 1, 400);
        send_chk("t4.f1", 0, 128, 0, 0, 1, 0);
        send_chk("t4.f2", 0, 128, 0, 0, 1, 0);
        send_chk("t4.f3", 0, 128, 0, 0, 1, 0);
        send_chk("t4.run", 100, 128, 300, 1, 1, FB ? 300 : 100);

        // ---------------- saturation, gain 255/256 ----------------
        restart("t2p", 1'b1);
        for (int i = 0; i < DELAY; i++) send_chk("t2p.fill", 30000, 255, 30000, 0, 1, 30000);
        send_chk("t2p.sat", 30000, 255, 32767, 1, 1, FB ? 32767 : 30000);
        restart("t2n", 1'b1);
        for (int i = 0; i < DELAY; i++) send_chk("t2n.fill", -30000, 255, -30000, 0, 1, -30000);
        send_chk("t2n.sat", -30000, 255, -32768, 1, 1, FB ? -32768 : -30000);

        // ---------------- strobe while busy ----------------
        restart("t3", 1'b0);
        @(negedge clk);
        vc0 = valid_cnt;
        s_valid = 1'b1; sample = 77; gain = 128;
        #1 check_eq("t3.drop_c0", drop, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #1 check_eq("t3.drop_c1", drop, 0);
        @(negedge clk);
        s_valid = 1'b1; sample = 99;
        #1 check_eq("t3.drop_c2", drop, 1);
        @(negedge clk);
        s_valid = 1'b0; sample = '0;
        #1 check_eq("t3.drop_c3", drop, 0);
        @(negedge clk);
        check_eq("t3.valid_c4", out_valid, 1);
        check_eq("t3.out", $signed(out_sample), 77);
        repeat (6) @(negedge clk);
        check_eq("t3.strobes", valid_cnt - vc0, 1);

        // ---------------- echo decay (single vs feedback) ----------------
        @(negedge clk);
        enable = 1'b1;
        send_chk("t5.s0", 1024, 128, 1024, 0, 1, 1024);
        for (int i = 1; i < DELAY; i++) send_chk("t5.fill", 0, 128, 0, 0, 1, 0);
        send_chk("t5.s4", 0, 128, 512, 1, 1, FB ? 512 : 0);
        for (int i = 5; i < 8; i++) send_chk("t5.mid", 0, 128, 0, 1, 1, 0);
        send_chk("t5.s8", 0, 128, FB ? 256 : 0, 1, 1, FB ? 256 : 0);

        // ---------------- read while FIFO empty ----------------
        check_eq("err.before", err, 0);
        force_empty = 1'b1;
        send_chk("err.s", 50, 128, 50, 0, 1, 50);
        check_eq("err.set", err, 1);
        force_empty = 1'b0;
        send_chk("err.next", 60, 128, 60, 1, 1, 60);
        check_eq("err.sticky", err, 1);

        // ---------------- reset mid-sample ----------------
        @(negedge clk);
        vc0 = valid_cnt;
        s_valid = 1'b1; sample = 500; gain = 128;
        @(negedge clk);
        s_valid = 1'b0; sample = '0; gain = '0;
        @(negedge clk);
        sreset = 1'b1;
        #1 check_eq("t6.rd", fifo_rd, 0);
        @(negedge clk);
        check_eq("t6.valid", out_valid, 0);
        check_eq("t6.out", $signed(out_sample), 0);
        check_eq("t6.wr", fifo_wr, 0);
        check_eq("t6.wdata", $signed(fifo_wdata), 0);
        check_eq("t6.err", err, 0);
        check_eq("t6.drop", drop, 0);
        check_eq("t6.flush", fifo_flush, 0);
        check_eq("t6.state", dut.state_q, ST_IDLE);
        @(negedge clk);
        sreset = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t6.strobes", valid_cnt - vc0, 0);
        send_chk("t6.after", 321, 128, 321, 0, 1, 321);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
